// File: rtl/setting_blitter.sv
// Settings sprite blitter: scans the 3x-scaled plus/minus sprite ROM in raster order
// and streams the returned pixels into the framebuffer with edge clipping and colour key.
module setting_blitter #(
    parameter int          SPR_W       = 132,
    parameter int          SPR_H       = 162,
    parameter int          FB_WIDTH    = 320,
    parameter int          FB_HEIGHT   = 240,
    parameter int          ROM_LATENCY = 1,
    parameter logic [15:0] KEY_COLOR   = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode_sel,
    input  logic        key_en,
    input  logic [8:0]  dest_x,
    input  logic [7:0]  dest_y,
    input  logic        abort,
    output logic        rom_mode,
    output logic [7:0]  rom_addr_x,
    output logic [7:0]  rom_addr_y,
    input  logic [15:0] rom_data,
    output logic        fb_we,
    output logic [16:0] fb_addr,
    output logic [15:0] fb_data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] X_LAST     = 8'(SPR_W - 1);
    localparam logic [7:0] Y_LAST     = 8'(SPR_H - 1);
    localparam logic [9:0] FB_W_LIM   = 10'(FB_WIDTH);
    localparam logic [8:0] FB_H_LIM   = 9'(FB_HEIGHT);
    localparam logic [1:0] DRAIN_LAST = 2'(ROM_LATENCY);

    // Row-major framebuffer word address, truncated to the 17-bit port.
    function automatic logic [16:0] fb_addr_fn(input logic [9:0] fx, input logic [8:0] fy);
        logic [26:0] lin;
        lin = (27'(fy) * 27'(FB_WIDTH)) + 27'(fx);
        return lin[16:0];
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  rom_x_q, rom_x_d;
    logic [7:0]  rom_y_q, rom_y_d;
    logic        rom_mode_q, rom_mode_d;
    logic        key_en_q, key_en_d;
    logic [8:0]  dest_x_q, dest_x_d;
    logic [7:0]  dest_y_q, dest_y_d;
    logic [1:0]  drain_cnt_q, drain_cnt_d;
    logic        pv_q [ROM_LATENCY];
    logic        pv_d [ROM_LATENCY];
    logic [7:0]  px_q [ROM_LATENCY];
    logic [7:0]  px_d [ROM_LATENCY];
    logic [7:0]  py_q [ROM_LATENCY];
    logic [7:0]  py_d [ROM_LATENCY];
    logic        fb_we_q, fb_we_d;
    logic [16:0] fb_addr_q, fb_addr_d;
    logic [15:0] fb_data_q, fb_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        scan_last_s;
    logic        flush_s;
    logic [9:0]  fx_s;
    logic [8:0]  fy_s;
    logic        in_fb_s;
    logic        keyed_s;

    assign scan_last_s = (rom_x_q == X_LAST) && (rom_y_q == Y_LAST);
    // An abort only matters while a blit is actually moving pixels.
    assign flush_s     = abort && ((state_q == S_SCAN) || (state_q == S_DRAIN));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SCAN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SCAN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (scan_last_s) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_SCAN;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Blit parameter latch, ROM address walk and drain counter.
    always_comb begin
        rom_x_d     = rom_x_q;
        rom_y_d     = rom_y_q;
        rom_mode_d  = rom_mode_q;
        key_en_d    = key_en_q;
        dest_x_d    = dest_x_q;
        dest_y_d    = dest_y_q;
        drain_cnt_d = 2'd0;
        if ((state_q == S_IDLE) && start) begin
            rom_x_d    = 8'd0;
            rom_y_d    = 8'd0;
            rom_mode_d = mode_sel;
            key_en_d   = key_en;
            dest_x_d   = dest_x;
            dest_y_d   = dest_y;
        end else if ((state_q == S_SCAN) && !abort && !scan_last_s) begin
            if (rom_x_q == X_LAST) begin
                rom_x_d = 8'd0;
                rom_y_d = rom_y_q + 8'd1;
            end else begin
                rom_x_d = rom_x_q + 8'd1;
                rom_y_d = rom_y_q;
            end
        end else begin
            rom_x_d = rom_x_q;
            rom_y_d = rom_y_q;
        end
        if (state_q == S_DRAIN) begin
            drain_cnt_d = drain_cnt_q + 2'd1;
        end else begin
            drain_cnt_d = 2'd0;
        end
    end

    // Coordinate delay line that keeps each address aligned with its ROM pixel.
    always_comb begin
        for (int i = 0; i < ROM_LATENCY; i++) begin
            pv_d[i] = 1'b0;
            px_d[i] = px_q[i];
            py_d[i] = py_q[i];
        end
        pv_d[0] = (state_q == S_SCAN) && !flush_s;
        px_d[0] = rom_x_q;
        py_d[0] = rom_y_q;
        for (int i = 1; i < ROM_LATENCY; i++) begin
            pv_d[i] = pv_q[i-1] && !flush_s;
            px_d[i] = px_q[i-1];
            py_d[i] = py_q[i-1];
        end
    end

    assign fx_s    = {2'b00, px_q[ROM_LATENCY-1]} + {1'b0, dest_x_q};
    assign fy_s    = {1'b0, py_q[ROM_LATENCY-1]} + {1'b0, dest_y_q};
    assign in_fb_s = (fx_s < FB_W_LIM) && (fy_s < FB_H_LIM);
    assign keyed_s = key_en_q && (rom_data == KEY_COLOR);

    // Framebuffer write stage plus status flags; address/data hold when no write.
    always_comb begin
        fb_we_d   = 1'b0;
        fb_addr_d = fb_addr_q;
        fb_data_d = fb_data_q;
        if (pv_q[ROM_LATENCY-1] && !flush_s && in_fb_s && !keyed_s) begin
            fb_we_d   = 1'b1;
            fb_addr_d = fb_addr_fn(fx_s, fy_s);
            fb_data_d = rom_data;
        end else begin
            fb_we_d   = 1'b0;
        end
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_x_q     <= 8'd0;
            rom_y_q     <= 8'd0;
            rom_mode_q  <= 1'b0;
            key_en_q    <= 1'b0;
            dest_x_q    <= 9'd0;
            dest_y_q    <= 8'd0;
            drain_cnt_q <= 2'd0;
            for (int i = 0; i < ROM_LATENCY; i++) begin
                pv_q[i] <= 1'b0;
                px_q[i] <= 8'd0;
                py_q[i] <= 8'd0;
            end
            fb_we_q     <= 1'b0;
            fb_addr_q   <= 17'd0;
            fb_data_q   <= 16'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            rom_x_q     <= rom_x_d;
            rom_y_q     <= rom_y_d;
            rom_mode_q  <= rom_mode_d;
            key_en_q    <= key_en_d;
            dest_x_q    <= dest_x_d;
            dest_y_q    <= dest_y_d;
            drain_cnt_q <= drain_cnt_d;
            for (int i = 0; i < ROM_LATENCY; i++) begin
                pv_q[i] <= pv_d[i];
                px_q[i] <= px_d[i];
                py_q[i] <= py_d[i];
            end
            fb_we_q     <= fb_we_d;
            fb_addr_q   <= fb_addr_d;
            fb_data_q   <= fb_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rom_mode   = rom_mode_q;
    assign rom_addr_x = rom_x_q;
    assign rom_addr_y = rom_y_q;
    assign fb_we      = fb_we_q;
    assign fb_addr    = fb_addr_q;
    assign fb_data    = fb_data_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_setting_blitter.sv
// Directed bench for setting_blitter: full, clipped, keyed, aborted and reset-interrupted blits
// against a one-cycle ROM model returning {y,x} (optionally zero on even x).
module tb_setting_blitter;

    localparam int EV_NONE  = 0;
    localparam int EV_START = 1;
    localparam int EV_ABORT = 2;
    localparam int EV_RST   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode_sel;
    logic        key_en;
    logic [8:0]  dest_x;
    logic [7:0]  dest_y;
    logic        abort;
    logic        rom_mode;
    logic [7:0]  rom_addr_x;
    logic [7:0]  rom_addr_y;
    logic [15:0] rom_data = 16'h0000;
    logic        fb_we;
    logic [16:0] fb_addr;
    logic [15:0] fb_data;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    int cur_pat = 0;
    int cur_dx, cur_dy;
    logic exp_mode;
    logic chk_order;
    int wr_cnt, zero_wr, geom_err, ord_err, mode_err;
    int first_wr, last_wr, done_cnt, done_cyc, busy_cnt, first_busy, last_busy;
    logic [16:0] first_addr, last_addr;
    logic [7:0]  a1x, a1y;

    setting_blitter dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode_sel   (mode_sel),
        .key_en     (key_en),
        .dest_x     (dest_x),
        .dest_y     (dest_y),
        .abort      (abort),
        .rom_mode   (rom_mode),
        .rom_addr_x (rom_addr_x),
        .rom_addr_y (rom_addr_y),
        .rom_data   (rom_data),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_fn(input int pat, input logic [7:0] x, input logic [7:0] y);
        if (pat == 1 && x[0] == 1'b0) return 16'h0000;
        return {y, x};
    endfunction

    // Sprite ROM model, one cycle of read latency.
    always @(posedge clk) rom_data <= rom_fn(cur_pat, rom_addr_x, rom_addr_y);

    function automatic logic [63:0] out_vec();
        return 64'({rom_mode, rom_addr_x, rom_addr_y, fb_we, fb_addr, fb_data, busy, done});
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        wr_cnt = 0; zero_wr = 0; geom_err = 0; ord_err = 0; mode_err = 0;
        first_wr = -1; last_wr = -1; done_cnt = 0; done_cyc = -1;
        busy_cnt = 0; first_busy = -1; last_busy = -1;
        first_addr = 17'd0; last_addr = 17'd0;
    endtask

    task automatic sample(input int c);
        int ax, ay, ex, ey;
        if (fb_we) begin
            if (wr_cnt == 0) begin
                first_wr   = c;
                first_addr = fb_addr;
            end
            last_wr   = c;
            last_addr = fb_addr;
            if (fb_data == 16'h0000) begin
                zero_wr++;
            end else begin
                ax = int'(fb_addr) % 320;
                ay = int'(fb_addr) / 320;
                if ((ax - cur_dx) != int'(fb_data[7:0]) || (ay - cur_dy) != int'(fb_data[15:8])) geom_err++;
            end
            if (chk_order) begin
                ex = wr_cnt % 132;
                ey = wr_cnt / 132;
                if (fb_addr != 17'(ey * 320 + ex) || fb_data != rom_fn(cur_pat, 8'(ex), 8'(ey))) ord_err++;
            end
            wr_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = c;
        end
        if (busy) begin
            if (busy_cnt == 0) first_busy = c;
            busy_cnt++;
            last_busy = c;
            if (rom_mode != exp_mode) mode_err++;
        end
    endtask

    // Start sampled at edge 0; cycle c is the interval ending at edge c, sampled mid-cycle.
    task automatic run_blit(input logic m, input logic k, input logic [8:0] dx, input logic [7:0] dy,
                            input int pat, input int ev, input int ev_c, input int n);
        clr_mon();
        cur_pat = pat; cur_dx = int'(dx); cur_dy = int'(dy); exp_mode = m;
        @(negedge clk);
        start = 1'b1; mode_sel = m; key_en = k; dest_x = dx; dest_y = dy;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            sample(c);
            if (c == 1) begin
                a1x = rom_addr_x;
                a1y = rom_addr_y;
            end
            if (c == ev_c) begin
                case (ev)
                    EV_START: begin
                        start = 1'b1; mode_sel = ~m; key_en = ~k; dest_x = 9'd7; dest_y = 8'd3;
                    end
                    EV_ABORT: abort = 1'b1;
                    EV_RST: begin
                        rst = 1'b0;
                        #1;
                        check_eq("rst_async_outputs_zero", out_vec(), 64'd0);
                        clr_mon();
                    end
                    default: ;
                endcase
            end else if (c == ev_c + 1) begin
                start = 1'b0;
                abort = 1'b0;
            end else if (ev == EV_RST && c == ev_c + 3) begin
                rst = 1'b1;
            end
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; mode_sel = 1'b0; key_en = 1'b0;
        dest_x = 9'd0; dest_y = 8'd0; abort = 1'b0; chk_order = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs_zero", out_vec(), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Reset at cycle 500 of a blit, then idle.
        run_blit(1'b0, 1'b0, 9'd0, 8'd0, 0, EV_RST, 500, 520);
        check_eq("post_reset_no_writes", 64'(wr_cnt), 64'd0);
        check_eq("post_reset_not_busy", 64'(busy_cnt), 64'd0);
        check_eq("post_reset_no_done", 64'(done_cnt), 64'd0);

        // Full unclipped blit, even-x pixels zero, key disabled.
        chk_order = 1'b1;
        run_blit(1'b0, 1'b0, 9'd0, 8'd0, 1, EV_NONE, 0, 21390);
        chk_order = 1'b0;
        check_eq("full_writes", 64'(wr_cnt), 64'd21384);
        check_eq("full_zero_writes", 64'(zero_wr), 64'd10692);
        check_eq("full_order", 64'(ord_err), 64'd0);
        check_eq("full_geom", 64'(geom_err), 64'd0);
        check_eq("full_first_we_cyc", 64'(first_wr), 64'd3);
        check_eq("full_last_we_cyc", 64'(last_wr), 64'd21386);
        check_eq("full_first_addr", 64'(first_addr), 64'd0);
        check_eq("full_last_addr", 64'(last_addr), 64'd51651);
        check_eq("full_done_cyc", 64'(done_cyc), 64'd21387);
        check_eq("full_done_cnt", 64'(done_cnt), 64'd1);
        check_eq("full_busy_first", 64'(first_busy), 64'd1);
        check_eq("full_busy_last", 64'(last_busy), 64'd21387);
        check_eq("full_busy_cnt", 64'(busy_cnt), 64'd21387);
        check_eq("full_rom_mode", 64'(mode_err), 64'd0);

        // Clipped blit in minus mode, with an ignored start at cycle 100.
        run_blit(1'b1, 1'b0, 9'd250, 8'd200, 0, EV_START, 100, 21390);
        check_eq("clip_writes", 64'(wr_cnt), 64'd2800);
        check_eq("clip_first_addr", 64'(first_addr), 64'd64250);
        check_eq("clip_last_addr", 64'(last_addr), 64'd76799);
        check_eq("clip_geom", 64'(geom_err), 64'd0);
        check_eq("clip_done_cyc", 64'(done_cyc), 64'd21387);
        check_eq("clip_done_cnt", 64'(done_cnt), 64'd1);
        check_eq("mode_held_minus", 64'(mode_err), 64'd0);

        // Colour-key transparency.
        run_blit(1'b0, 1'b1, 9'd0, 8'd0, 1, EV_NONE, 0, 21390);
        check_eq("key_writes", 64'(wr_cnt), 64'd10692);
        check_eq("key_zero_writes", 64'(zero_wr), 64'd0);
        check_eq("key_geom", 64'(geom_err), 64'd0);
        check_eq("key_done_cyc", 64'(done_cyc), 64'd21387);

        // Abort at cycle 1000.
        run_blit(1'b0, 1'b0, 9'd0, 8'd0, 0, EV_ABORT, 1000, 1010);
        check_eq("abort_busy_last", 64'(last_busy), 64'd1000);
        check_eq("abort_last_we", 64'(last_wr), 64'd1000);
        check_eq("abort_no_done", 64'(done_cnt), 64'd0);
        check_eq("abort_addr_x_hold", 64'(rom_addr_x), 64'd75);
        check_eq("abort_addr_y_hold", 64'(rom_addr_y), 64'd7);

        // Restart after abort begins at (0,0).
        run_blit(1'b0, 1'b0, 9'd0, 8'd0, 0, EV_ABORT, 5, 12);
        check_eq("restart_addr_x", 64'(a1x), 64'd0);
        check_eq("restart_addr_y", 64'(a1y), 64'd0);
        check_eq("restart_abort_not_busy", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/setting_blitter.md
Name: setting_blitter

Overview:
- Initiator/writer counterpart of the settings sprite ROM reader.
- On `start`, it drives the sprite ROM x/y address pair across the full 3x-scaled sprite (132x162 pixels) and selects the plus or minus image.
- It captures the returned 16-bit pixels and writes them into a framebuffer write port at a requested origin.
- Writes are clipped at the framebuffer edge, with optional colour-key transparency; the block sits between the settings menu FSM and the framebuffer RAM.

Parameters:
- SPR_W, 132, scaled sprite width (44*3)
- SPR_H, 162, scaled sprite height (54*3)
- FB_WIDTH, 320, framebuffer width in pixels
- FB_HEIGHT, 240, framebuffer height in pixels
- ROM_LATENCY, 1, cycles from ROM address to valid `rom_data` (1..3)
- KEY_COLOR, 16'h0000, transparent colour value

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a blit
- mode_sel  in  1  0 = plus image, 1 = minus image; sampled with `start`
- key_en  in  1  1 = skip pixels equal to KEY_COLOR; sampled with `start`
- dest_x  in  9  framebuffer x origin; sampled with `start`
- dest_y  in  8  framebuffer y origin; sampled with `start`
- abort  in  1  terminate the current blit
- rom_mode  out  1  drives the ROM `cnt_mode` input
- rom_addr_x  out  8  ROM scaled x address
- rom_addr_y  out  8  ROM scaled y address
- rom_data  in  16  ROM pixel, ROM_LATENCY cycles after the address
- fb_we  out  1  framebuffer write enable
- fb_addr  out  17  framebuffer word address
- fb_data  out  16  framebuffer write data
- busy  out  1  blit in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (`rst` = 0, asynchronous):
  - state = IDLE.
  - All outputs 0: `rom_addr_x`/`rom_addr_y`, `rom_mode`, `fb_we`, `fb_addr`, `fb_data`, `busy`, `done`.
  - Pipeline valid bits cleared; no write is ever emitted from a cycle overlapping reset.
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - `start` = 1 latches `mode_sel`, `key_en`, `dest_x`, `dest_y` into internal registers.
  - Next state SCAN; `rom_addr` = (0,0); `rom_mode` = latched `mode_sel`.
  - `abort` is ignored in IDLE.
- SCAN:
  - Exactly one address is issued per cycle, raster order.
  - x increments; at x = SPR_W-1, x wraps to 0 and y increments.
  - After the cycle issuing (SPR_W-1, SPR_H-1), next state is DRAIN.
  - All outputs are registered.
- Read pipeline:
  - The address issued in cycle n is paired with the `rom_data` sampled at the end of cycle n+ROM_LATENCY.
  - The x/y coordinates travel in a ROM_LATENCY-deep delay line with a valid bit.
  - The resulting write appears on the `fb_*` outputs in cycle n+ROM_LATENCY+1.
- Write rules, with fx = `dest_x` + x (10-bit) and fy = `dest_y` + y (9-bit):
  - `fb_we` = 1 only if fx < FB_WIDTH, fy < FB_HEIGHT, and NOT (`key_en` && `rom_data` == KEY_COLOR).
  - `fb_addr` = fy*FB_WIDTH + fx, truncated to 17 bits.
  - `fb_data` = `rom_data`.
  - When `fb_we` = 0, `fb_addr`/`fb_data` hold their previous values.
- DRAIN: remains until the pipeline is empty (ROM_LATENCY+1 cycles after the last address), then goes to DONE.
- DONE: `done` = 1 for exactly one cycle, then IDLE.
- `busy`: 1 from the first SCAN cycle through the DONE cycle inclusive; 0 in IDLE.
- Timing, defaults, `start` sampled at edge 0:
  - SCAN cycles 1..21384.
  - Last possible write in cycle 21386.
  - `done` in cycle 21387.
  - `busy` falls in cycle 21388.
- `start` while `busy` = 1: ignored; latched parameters are unchanged.
- `start` and `abort` together in IDLE: the blit starts.
- `abort` = 1 in SCAN/DRAIN:
  - Next state IDLE, `busy` = 0, pipeline valids flushed.
  - `fb_we` = 0 from the next cycle; no `done` pulse.
- `abort` in DONE: `done` still pulses; return to IDLE.
- `rom_addr` holds its last issued value in DRAIN, DONE and IDLE.

Test Plan:
- Reset mid-blit:
  - Start; assert `rst` = 0 at cycle 500.
  - Required: all outputs 0 immediately; `fb_we` never 1 until the next `start`; a new `start` runs a full blit normally.
- Full blit, dest (0,0), `key_en` = 0, ROM model returning {y,x}:
  - Required: 21384 writes, `fb_addr` 0..(161*320+131) raster order, first `fb_we` at cycle 3.
  - Required: `done` at cycle 21387, `busy` 1 for cycles 1..21387.
- Clipping, dest (250,200):
  - Required: writes only for x<70, y<40; 2800 writes total.
  - Required: first `fb_addr` = 200*320+250 = 64250; `done` at the same cycle as an unclipped blit.
- Transparency, `key_en` = 1, ROM returns 16'h0000 on every even x:
  - Required: 10692 writes, none carrying 16'h0000.
  - Repeat with `key_en` = 0: 21384 writes.
- Mode and `start`-while-busy:
  - Start with `mode_sel` = 1; pulse `start` with `mode_sel` = 0 at cycle 100.
  - Required: `rom_mode` stays 1 for the whole blit; one `done` only.
- Abort at cycle 1000:
  - Required: `busy` 0 at cycle 1001, no `fb_we` from cycle 1001, no `done`.
  - Required: a later `start` restarts at `rom_addr` (0,0).
